fir_stream_adapter: RTL and testbench
=====================================

FIR_STREAM_ADAPTER -- requirements
Module: fir_stream_adapter

Interface
REQ-001 SHALL have parameter SAMPLES_NUM, default 4, legal 1..8; sets samples per FIR block.
REQ-002 SHALL have port clkIn  input  1  the single clock; all state on its rising edge.
REQ-003 SHALL have port nResetIn  input  1  reset, asynchronous and active-low.
REQ-004 SHALL have port sampleValidIn  input  1  upstream sample valid.
REQ-005 SHALL have port sampleIn  input  16  signed sample.
REQ-006 SHALL have port sampleReadyOut  output  1  adapter accepts sample this cycle.
REQ-007 SHALL have port firStartOut  output  1  start pulse to the FIR block.
REQ-008 SHALL have port firDataOut  output  16*SAMPLES_NUM  packed sample block to the FIR block.
REQ-009 SHALL have port firBusyIn  input  1  FIR block busy.
REQ-010 SHALL have port firDoneIn  input  1  FIR one-cycle done pulse.
REQ-011 SHALL have port firDataIn  input  32*SAMPLES_NUM  FIR saturated results.
REQ-012 SHALL have port resultValidOut  output  1  result word valid.
REQ-013 SHALL have port resultOut  output  32  result word.
REQ-014 SHALL have port resultReadyIn  input  1  downstream accepts result.
REQ-015 SHALL have port protocolErrorOut  output  1  sticky FIR handshake error.

Function
REQ-016 Sample transfer SHALL occur on a cycle with sampleValidIn=1 and sampleReadyOut=1.
REQ-017 sampleReadyOut SHALL be 1 exactly when collect count < SAMPLES_NUM (registered count, no combinational path from valid).
REQ-018 k-th accepted sample of a block (k=0 first) SHALL land in collect slice [16k+15:16k].
REQ-019 FIR-side FSM SHALL have states IDLE, WAIT; IDLE->WAIT on launch, WAIT->IDLE on firDoneIn.
REQ-020 Launch condition: state IDLE, count==SAMPLES_NUM, firBusyIn=0, emit side empty (no result words pending).
REQ-021 On launch cycle SHALL register firDataOut<=collect buffer, firStartOut=1 for exactly one cycle, count<=0.
REQ-022 firDataOut SHALL hold stable from launch until the firDoneIn cycle inclusive.
REQ-023 In WAIT, on firDoneIn=1 SHALL capture firDataIn into the emit register same edge, load emit count SAMPLES_NUM, go IDLE.
REQ-024 Emit order SHALL be most-significant slice first: firDataIn[32N-1 -: 32] first, [31:0] last.
REQ-025 resultValidOut SHALL be 1 while emit count > 0; resultOut SHALL be the current slice, stable while valid and not ready.
REQ-026 On resultValidOut=1 and resultReadyIn=1 SHALL advance to next slice and decrement emit count.
REQ-027 Collection SHALL continue during WAIT and emit; next block launches only when REQ-020 holds.
REQ-028 A sample SHALL be acceptable the cycle after launch (count cleared).
REQ-029 firDoneIn=1 while state IDLE SHALL be ignored for data and SHALL set protocolErrorOut=1 until reset.
REQ-030 firBusyIn=1 in IDLE SHALL block launch without error.
REQ-031 Latency: last sample accepted at edge t -> firStartOut=1 in cycle t+1 when REQ-020 holds.
REQ-032 No arithmetic on data; results passed bit-exact.

Reset
REQ-033 nResetIn=0 SHALL immediately clear: state IDLE, counts 0, firStartOut 0, firDataOut 0, resultValidOut 0, resultOut 0, protocolErrorOut 0, sampleReadyOut 1 after release.
REQ-034 Reset mid-block or mid-emit SHALL discard partial samples and pending results; no start pulse on release.

Structure
REQ-035 Shared package SHALL hold SAMPLE_WIDTH=16, RESULT_WIDTH=32, max SAMPLES_NUM=8 and the FSM state enum.
REQ-036 No sub-module; collect, FIR-side FSM and emit serializer SHALL live in one module.

Verification
REQ-037 N=4, samples 1,2,3,4 back-to-back, firBusyIn=0 -> firStartOut one cycle after 4th accept, firDataOut=0x0004_0003_0002_0001.
REQ-038 Done with firDataIn={A,B,C,D}, resultReadyIn=1 -> resultOut A,B,C,D on 4 consecutive cycles, then valid 0.
REQ-039 resultReadyIn toggled 1,0,0,1 -> resultOut held during stalls, no word lost or repeated.
REQ-040 8 samples streamed while FIR busy/emitting -> second start only after 4th word of first result accepted; sampleReadyOut 0 after 8th sample until launch.
REQ-041 firDoneIn pulsed in IDLE -> protocolErrorOut=1 sticky, no resultValidOut.
REQ-042 nResetIn low after 2 samples and in WAIT -> all outputs zero; fresh 4 samples produce correct block, no spurious start.

Source files
------------

// File: rtl/fir_stream_adapter_pkg.sv
// Shared widths, sizing limits and FIR-side FSM state encoding for fir_stream_adapter.
package fir_stream_adapter_pkg;

  localparam int SAMPLE_WIDTH    = 16;
  localparam int RESULT_WIDTH    = 32;
  localparam int MAX_SAMPLES_NUM = 8;
  localparam int COUNT_WIDTH     = $clog2(MAX_SAMPLES_NUM + 1);

  typedef enum logic {
    IDLE = 1'b0,
    WAIT = 1'b1
  } firState_t;

endpackage

// File: rtl/fir_stream_adapter.sv
// Packs SAMPLES_NUM samples into a FIR block, launches it one cycle after the last sample, and serializes results MSB slice first.
// Sample ready is registered-count based; a new launch waits for FIR idle and all prior result words to drain.
module fir_stream_adapter
  import fir_stream_adapter_pkg::*;
#(
  parameter int SAMPLES_NUM = 4
) (
  input  logic                                 clkIn,
  input  logic                                 nResetIn,
  input  logic                                 sampleValidIn,
  input  logic [SAMPLE_WIDTH-1:0]              sampleIn,
  output logic                                 sampleReadyOut,
  output logic                                 firStartOut,
  output logic [SAMPLE_WIDTH*SAMPLES_NUM-1:0]  firDataOut,
  input  logic                                 firBusyIn,
  input  logic                                 firDoneIn,
  input  logic [RESULT_WIDTH*SAMPLES_NUM-1:0]  firDataIn,
  output logic                                 resultValidOut,
  output logic [RESULT_WIDTH-1:0]              resultOut,
  input  logic                                 resultReadyIn,
  output logic                                 protocolErrorOut
);

  localparam logic [COUNT_WIDTH-1:0] FULL_COUNT = COUNT_WIDTH'(SAMPLES_NUM);

  firState_t                          state;
  logic [COUNT_WIDTH-1:0]             collectCount;
  logic [COUNT_WIDTH-1:0]             emitCount;
  logic [SAMPLE_WIDTH*SAMPLES_NUM-1:0] collectBuf;
  logic [RESULT_WIDTH*SAMPLES_NUM-1:0] emitBuf;

  logic sampleAccept;
  logic launch;
  logic doneCapture;
  logic resultAccept;

  assign sampleReadyOut = (collectCount < FULL_COUNT);
  assign sampleAccept   = sampleValidIn && sampleReadyOut;

  // Emit side must be empty so one result block never overlaps the next.
  assign launch = (state == IDLE) && (collectCount == FULL_COUNT) &&
                  !firBusyIn && (emitCount == '0);

  assign doneCapture    = (state == WAIT) && firDoneIn;
  assign resultValidOut = (emitCount != '0);
  assign resultAccept   = resultValidOut && resultReadyIn;
  assign resultOut      = emitBuf[RESULT_WIDTH*SAMPLES_NUM-1 -: RESULT_WIDTH];

  always_ff @(posedge clkIn or negedge nResetIn) begin
    if (!nResetIn) begin
      collectCount <= '0;
      collectBuf   <= '0;
    end else if (launch) begin
      collectCount <= '0;
    end else if (sampleAccept) begin
      collectBuf[int'(collectCount)*SAMPLE_WIDTH +: SAMPLE_WIDTH] <= sampleIn;
      collectCount <= collectCount + 1'b1;
    end
  end

  always_ff @(posedge clkIn or negedge nResetIn) begin
    if (!nResetIn) begin
      state            <= IDLE;
      firStartOut      <= 1'b0;
      firDataOut       <= '0;
      protocolErrorOut <= 1'b0;
    end else begin
      firStartOut <= 1'b0;
      case (state)
        IDLE: begin
          // A done pulse with nothing outstanding is a FIR handshake violation.
          if (firDoneIn) begin
            protocolErrorOut <= 1'b1;
          end
          if (launch) begin
            firDataOut  <= collectBuf;
            firStartOut <= 1'b1;
            state       <= WAIT;
          end
        end
        WAIT: begin
          if (firDoneIn) begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clkIn or negedge nResetIn) begin
    if (!nResetIn) begin
      emitCount <= '0;
      emitBuf   <= '0;
    end else if (doneCapture) begin
      emitBuf   <= firDataIn;
      emitCount <= FULL_COUNT;
    end else if (resultAccept) begin
      emitBuf   <= emitBuf << RESULT_WIDTH;
      emitCount <= emitCount - 1'b1;
    end
  end

endmodule

// File: tb/tb_fir_stream_adapter.sv
// Directed bench for fir_stream_adapter: a cycle table for the main flow plus hand sequences for backpressure, errors and reset.
module tb_fir_stream_adapter;

  localparam int N = 4;

  logic            clkIn = 1'b0;
  logic            nResetIn = 1'b0;
  logic            sampleValidIn = 1'b0;
  logic [15:0]     sampleIn = '0;
  logic            sampleReadyOut;
  logic            firStartOut;
  logic [16*N-1:0] firDataOut;
  logic            firBusyIn = 1'b0;
  logic            firDoneIn = 1'b0;
  logic [32*N-1:0] firDataIn;
  logic            resultValidOut;
  logic [31:0]     resultOut;
  logic            resultReadyIn = 1'b0;
  logic            protocolErrorOut;

  localparam logic [31:0] WA = 32'hA1A1_0001;
  localparam logic [31:0] WB = 32'hB2B2_0002;
  localparam logic [31:0] WC = 32'hC3C3_0003;
  localparam logic [31:0] WD = 32'hD4D4_0004;
  localparam logic [63:0] F1 = 64'h0004_0003_0002_0001;
  localparam logic [63:0] F2 = 64'h0008_0007_0006_0005;
  localparam logic [63:0] F3 = 64'h000C_000B_000A_0009;

  assign firDataIn = {WA, WB, WC, WD};

  fir_stream_adapter #(.SAMPLES_NUM(N)) dut (
    .clkIn            (clkIn),
    .nResetIn         (nResetIn),
    .sampleValidIn    (sampleValidIn),
    .sampleIn         (sampleIn),
    .sampleReadyOut   (sampleReadyOut),
    .firStartOut      (firStartOut),
    .firDataOut       (firDataOut),
    .firBusyIn        (firBusyIn),
    .firDoneIn        (firDoneIn),
    .firDataIn        (firDataIn),
    .resultValidOut   (resultValidOut),
    .resultOut        (resultOut),
    .resultReadyIn    (resultReadyIn),
    .protocolErrorOut (protocolErrorOut)
  );

  always #5 clkIn = ~clkIn;

  typedef struct {
    logic        vld;
    logic [15:0] smp;
    logic        busy;
    logic        done;
    logic        rrdy;
    logic        expRdy;
    logic        expStart;
    logic        expVld;
    logic [31:0] expRes;
    logic [63:0] expFir;
  } vec_t;

  localparam int NVEC = 23;
  vec_t vecs[NVEC];

  int nCmp = 0;
  int nErr = 0;

  function automatic vec_t mk(input logic vld, input logic [15:0] smp, input logic busy,
                              input logic done, input logic rrdy, input logic expRdy,
                              input logic expStart, input logic expVld,
                              input logic [31:0] expRes, input logic [63:0] expFir);
    vec_t v;
    v.vld = vld; v.smp = smp; v.busy = busy; v.done = done; v.rrdy = rrdy;
    v.expRdy = expRdy; v.expStart = expStart; v.expVld = expVld;
    v.expRes = expRes; v.expFir = expFir;
    return v;
  endfunction

  task automatic cyc();
    @(posedge clkIn);
    @(negedge clkIn);
  endtask

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    nCmp++;
    if (act !== exp) begin
      nErr++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic sendSample(input logic [15:0] v);
    bit got;
    got = 1'b0;
    sampleValidIn = 1'b1;
    sampleIn      = v;
    for (int i = 0; i < 20; i++) begin
      if (sampleReadyOut) begin
        cyc();
        got = 1'b1;
        break;
      end
      cyc();
    end
    sampleValidIn = 1'b0;
    nCmp++;
    if (!got) begin
      nErr++;
      $display("FAIL sendSample %0h: got no ready, expected accept within 20 cycles", v);
    end
  endtask

  task automatic doReset();
    nResetIn      = 1'b0;
    sampleValidIn = 1'b0;
    sampleIn      = '0;
    firBusyIn     = 1'b0;
    firDoneIn     = 1'b0;
    resultReadyIn = 1'b0;
    cyc();
    cyc();
    nResetIn = 1'b1;
  endtask

  task automatic checkZero(input string tag);
    check({tag, ".start"}, 64'(firStartOut), 64'd0);
    check({tag, ".fir"},   firDataOut, 64'd0);
    check({tag, ".vld"},   64'(resultValidOut), 64'd0);
    check({tag, ".res"},   64'(resultOut), 64'd0);
    check({tag, ".err"},   64'(protocolErrorOut), 64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no end of test, expected completion within 200us");
    $fatal(1);
  end

  initial begin
    //              vld smp    bsy dn rr  rdy st vld res  fir
    vecs[0]  = mk(1, 16'd1, 0, 0, 0,  1, 0, 0, '0, '0);
    vecs[1]  = mk(1, 16'd2, 0, 0, 0,  1, 0, 0, '0, '0);
    vecs[2]  = mk(1, 16'd3, 0, 0, 0,  1, 0, 0, '0, '0);
    vecs[3]  = mk(1, 16'd4, 0, 0, 0,  0, 0, 0, '0, '0);
    vecs[4]  = mk(0, 16'd0, 0, 0, 0,  1, 1, 0, '0, F1);
    vecs[5]  = mk(0, 16'd0, 0, 0, 0,  1, 0, 0, '0, F1);
    vecs[6]  = mk(0, 16'd0, 0, 1, 1,  1, 0, 1, WA, F1);
    vecs[7]  = mk(0, 16'd0, 0, 0, 1,  1, 0, 1, WB, F1);
    vecs[8]  = mk(0, 16'd0, 0, 0, 1,  1, 0, 1, WC, F1);
    vecs[9]  = mk(0, 16'd0, 0, 0, 1,  1, 0, 1, WD, F1);
    vecs[10] = mk(0, 16'd0, 0, 0, 1,  1, 0, 0, '0, F1);
    vecs[11] = mk(1, 16'd5, 0, 0, 0,  1, 0, 0, '0, F1);
    vecs[12] = mk(1, 16'd6, 0, 0, 0,  1, 0, 0, '0, F1);
    vecs[13] = mk(1, 16'd7, 0, 0, 0,  1, 0, 0, '0, F1);
    vecs[14] = mk(1, 16'd8, 0, 0, 0,  0, 0, 0, '0, F1);
    vecs[15] = mk(0, 16'd0, 0, 0, 0,  1, 1, 0, '0, F2);
    vecs[16] = mk(0, 16'd0, 0, 1, 1,  1, 0, 1, WA, F2);
    vecs[17] = mk(0, 16'd0, 0, 0, 1,  1, 0, 1, WB, F2);
    vecs[18] = mk(0, 16'd0, 0, 0, 0,  1, 0, 1, WB, F2);
    vecs[19] = mk(0, 16'd0, 0, 0, 0,  1, 0, 1, WB, F2);
    vecs[20] = mk(0, 16'd0, 0, 0, 1,  1, 0, 1, WC, F2);
    vecs[21] = mk(0, 16'd0, 0, 0, 1,  1, 0, 1, WD, F2);
    vecs[22] = mk(0, 16'd0, 0, 0, 1,  1, 0, 0, '0, F2);

    @(negedge clkIn);
    #1;
    checkZero("reset.held");
    @(negedge clkIn);
    doReset();
    checkZero("reset.released");
    check("reset.rdy", 64'(sampleReadyOut), 64'd1);

    // Main flow: collect, launch, capture, emit with and without stalls.
    for (int i = 0; i < NVEC; i++) begin
      sampleValidIn = vecs[i].vld;
      sampleIn      = vecs[i].smp;
      firBusyIn     = vecs[i].busy;
      firDoneIn     = vecs[i].done;
      resultReadyIn = vecs[i].rrdy;
      cyc();
      check($sformatf("vec%0d.rdy", i),   64'(sampleReadyOut), 64'(vecs[i].expRdy));
      check($sformatf("vec%0d.start", i), 64'(firStartOut),    64'(vecs[i].expStart));
      check($sformatf("vec%0d.vld", i),   64'(resultValidOut), 64'(vecs[i].expVld));
      check($sformatf("vec%0d.res", i),   64'(resultOut),      64'(vecs[i].expRes));
      check($sformatf("vec%0d.fir", i),   firDataOut,          vecs[i].expFir);
      check($sformatf("vec%0d.err", i),   64'(protocolErrorOut), 64'd0);
    end

    // Second block collected while the first is outstanding launches only after the last word drains.
    doReset();
    for (int k = 1; k <= 4; k++) sendSample(16'(k));
    cyc();
    check("stream.start1", 64'(firStartOut), 64'd1);
    for (int k = 5; k <= 8; k++) sendSample(16'(k));
    check("stream.rdyFull", 64'(sampleReadyOut), 64'd0);
    repeat (3) begin
      cyc();
      check("stream.waitStart", 64'(firStartOut), 64'd0);
      check("stream.waitRdy", 64'(sampleReadyOut), 64'd0);
    end
    firDoneIn = 1'b1;
    cyc();
    firDoneIn = 1'b0;
    check("stream.resA", 64'(resultOut), 64'(WA));
    resultReadyIn = 1'b1;
    cyc();
    check("stream.resB", 64'(resultOut), 64'(WB));
    cyc();
    check("stream.resC", 64'(resultOut), 64'(WC));
    cyc();
    check("stream.resD", 64'(resultOut), 64'(WD));
    resultReadyIn = 1'b0;
    repeat (2) begin
      cyc();
      check("stream.stallStart", 64'(firStartOut), 64'd0);
      check("stream.stallRes", 64'(resultOut), 64'(WD));
    end
    resultReadyIn = 1'b1;
    cyc();
    resultReadyIn = 1'b0;
    check("stream.drained", 64'(resultValidOut), 64'd0);
    check("stream.noEarlyStart", 64'(firStartOut), 64'd0);
    cyc();
    check("stream.start2", 64'(firStartOut), 64'd1);
    check("stream.fir2", firDataOut, F2);
    check("stream.rdyAfterLaunch", 64'(sampleReadyOut), 64'd1);
    cyc();
    check("stream.startPulse", 64'(firStartOut), 64'd0);

    // Busy FIR holds off the launch without flagging an error.
    firDoneIn = 1'b1;
    cyc();
    firDoneIn = 1'b0;
    resultReadyIn = 1'b1;
    repeat (4) cyc();
    resultReadyIn = 1'b0;
    check("busy.drained", 64'(resultValidOut), 64'd0);
    firBusyIn = 1'b1;
    for (int k = 9; k <= 12; k++) sendSample(16'(k));
    repeat (3) begin
      cyc();
      check("busy.noStart", 64'(firStartOut), 64'd0);
      check("busy.noErr", 64'(protocolErrorOut), 64'd0);
    end
    firBusyIn = 1'b0;
    cyc();
    check("busy.start", 64'(firStartOut), 64'd1);
    check("busy.fir", firDataOut, F3);

    // Stray done in IDLE is sticky and produces no result.
    doReset();
    firDoneIn = 1'b1;
    cyc();
    firDoneIn = 1'b0;
    check("err.set", 64'(protocolErrorOut), 64'd1);
    check("err.noVld", 64'(resultValidOut), 64'd0);
    repeat (3) begin
      cyc();
      check("err.sticky", 64'(protocolErrorOut), 64'd1);
      check("err.stillNoVld", 64'(resultValidOut), 64'd0);
    end

    // Reset with a partial block (and the error still set).
    sendSample(16'h0001);
    sendSample(16'h0002);
    nResetIn = 1'b0;
    #1;
    checkZero("rst.partial");
    @(negedge clkIn);
    nResetIn = 1'b1;
    repeat (3) begin
      cyc();
      check("rst.partial.noStart", 64'(firStartOut), 64'd0);
      check("rst.partial.rdy", 64'(sampleReadyOut), 64'd1);
    end

    // Reset while in WAIT with results pending and a partial next block.
    for (int k = 1; k <= 4; k++) sendSample(16'(k));
    cyc();
    check("rst.wait.start", 64'(firStartOut), 64'd1);
    check("rst.wait.fir", firDataOut, F1);
    sendSample(16'h0005);
    sendSample(16'h0006);
    firDoneIn = 1'b1;
    cyc();
    firDoneIn = 1'b0;
    check("rst.wait.resA", 64'(resultOut), 64'(WA));
    nResetIn = 1'b0;
    #1;
    checkZero("rst.wait");
    @(negedge clkIn);
    nResetIn = 1'b1;
    repeat (3) begin
      cyc();
      check("rst.wait.noStart", 64'(firStartOut), 64'd0);
      check("rst.wait.noVld", 64'(resultValidOut), 64'd0);
    end
    for (int k = 9; k <= 12; k++) sendSample(16'(k));
    cyc();
    check("rst.fresh.start", 64'(firStartOut), 64'd1);
    check("rst.fresh.fir", firDataOut, F3);
    firDoneIn = 1'b1;
    cyc();
    firDoneIn = 1'b0;
    check("rst.fresh.resA", 64'(resultOut), 64'(WA));
    check("rst.fresh.vld", 64'(resultValidOut), 64'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nErr);
    $finish;
  end

endmodule
